// File: rtl/fp64_to_fixed_fifo.sv
// -----------------------------------------------------------------------------
// fp64_to_fixed_fifo
//
// Purpose:
//   Takes the 64-bit reduced-FP products of the 3-operand multiplier
//   (sign | exp[62:52], bias 1023 | fraction[51:0], hidden one; din[62:0]==0
//   means zero), converts each one to signed INT_W.FRAC_W fixed point in two
//   registered stages, and buffers the results in a first-word-fall-through
//   FIFO.
//   The multiplier cannot be back-pressured. 'stop' is therefore raised early
//   enough that an issuer halting on it never overflows the FIFO.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset; discards all data
//   pushin      in   din valid this cycle
//   din         in   64-bit FP product
//   stop        out  registered; upstream must not issue while high
//   dout_valid  out  FIFO head valid
//   dout_ready  in   consumer accepts head this cycle (ignored while empty)
//   dout        out  head value, two's complement, OUT_W bits
//   count       out  FIFO occupancy
//   ovf         out  sticky; a converted result was dropped on a full FIFO
// -----------------------------------------------------------------------------
module fp64_to_fixed_fifo #(
   parameter int INT_W       = 8,
   parameter int FRAC_W      = 24,
   parameter int DEPTH       = 16,
   parameter int STOP_MARGIN = 13,
   localparam int OUT_W      = INT_W + FRAC_W,
   localparam int CNT_W      = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pushin,
   input  logic [63:0]      din,
   output logic             stop,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic [OUT_W-1:0] dout,
   output logic [CNT_W-1:0] count,
   output logic             ovf
);

   localparam int AW = $clog2(DEPTH);

   // The shift is sh = e - 1075 + FRAC_W. It is held as 13-bit two's complement.
   localparam logic [12:0]      SH_OFFSET  = 13'(1075 - FRAC_W);
   // Any exponent at or above this value has |x| >= 2^(INT_W-1), so the result saturates.
   localparam logic [10:0]      SAT_EXP    = 11'(1023 + INT_W - 1);
   localparam logic [OUT_W-1:0] MAX_MAG    = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [CNT_W:0]   STOP_LEVEL = (CNT_W+1)'(DEPTH - STOP_MARGIN);
   localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);

   // Stage 1 registers
   logic             r_s1_valid;
   logic             r_s1_sign;
   logic [10:0]      r_s1_exp;
   logic [52:0]      r_s1_mant;
   logic             r_s1_zero;
   logic [12:0]      r_s1_sh;

   // Stage 2 registers
   logic             r_s2_valid;
   logic [OUT_W-1:0] r_s2_data;

   // FIFO state
   logic [OUT_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CNT_W-1:0] r_count;
   logic             r_ovf;
   logic             r_stop;

   // Combinational helpers
   logic [12:0]      w_nsh;
   logic [63:0]      w_mant_ext;
   logic [OUT_W-1:0] w_mag;
   logic [OUT_W-1:0] w_fixed;
   logic             w_empty;
   logic             w_full;
   logic             w_pop;
   logic             w_wr;
   logic             w_drop;
   logic [CNT_W-1:0] w_count_nxt;
   logic [CNT_W:0]   w_occupancy;

   // Stage 1: unpack the FP word and precompute the signed shift amount.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_sign  <= 1'b0;
         r_s1_exp   <= 11'd0;
         r_s1_mant  <= 53'd0;
         r_s1_zero  <= 1'b0;
         r_s1_sh    <= 13'd0;
      end else begin
         r_s1_valid <= pushin;
         r_s1_sign  <= din[63];
         r_s1_exp   <= din[62:52];
         r_s1_mant  <= {1'b1, din[51:0]};
         r_s1_zero  <= (din[62:0] == 63'd0);
         r_s1_sh    <= {2'b00, din[62:52]} - SH_OFFSET;
      end
   end

   // Stage 2 datapath: produce the magnitude (zero, saturate or shift), then apply the sign.
   always_comb begin
      w_nsh      = 13'd0 - r_s1_sh;
      w_mant_ext = {11'd0, r_s1_mant};
      w_mag      = {OUT_W{1'b0}};
      w_fixed    = {OUT_W{1'b0}};
      if (r_s1_zero) begin
         w_mag = {OUT_W{1'b0}};
      end else if (r_s1_exp >= SAT_EXP) begin
         w_mag = MAX_MAG;
      end else if (r_s1_sh[12] == 1'b0) begin
         // Left shift is only reachable when OUT_W > 53.
         w_mag = OUT_W'(w_mant_ext << r_s1_sh[5:0]);
      end else if (w_nsh >= 13'd53) begin
         w_mag = {OUT_W{1'b0}};
      end else begin
         w_mag = OUT_W'(w_mant_ext >> w_nsh[5:0]);
      end
      // Negating the magnitude gives symmetric saturation, -(2^(OUT_W-1)-1).
      if (r_s1_sign) begin
         w_fixed = (~w_mag) + {{(OUT_W-1){1'b0}}, 1'b1};
      end else begin
         w_fixed = w_mag;
      end
   end

   // Stage 2 register: the converted value waiting to be written into the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_data  <= {OUT_W{1'b0}};
      end else begin
         r_s2_valid <= r_s1_valid;
         r_s2_data  <= w_fixed;
      end
   end

   // FIFO control: pop/write/drop decisions and the next occupancy.
   always_comb begin
      w_empty     = (r_count == {CNT_W{1'b0}});
      w_full      = (r_count == FULL_CNT);
      w_pop       = dout_ready & ~w_empty;
      // A full FIFO still takes a write when it pops in the same cycle.
      w_wr        = r_s2_valid & (~w_full | w_pop);
      w_drop      = r_s2_valid & w_full & ~w_pop;
      w_count_nxt = r_count;
      case ({w_wr, w_pop})
         2'b10:   w_count_nxt = r_count + CNT_W'(1);
         2'b01:   w_count_nxt = r_count - CNT_W'(1);
         default: w_count_nxt = r_count;
      endcase
      w_occupancy = {1'b0, r_count} + {{CNT_W{1'b0}}, r_s1_valid}
                  + {{CNT_W{1'b0}}, r_s2_valid};
   end

   // FIFO storage. Its contents need no reset because dout is gated by dout_valid.
   always_ff @(posedge clk) begin
      if (w_wr && !rst) begin
         r_mem[r_wptr] <= r_s2_data;
      end else begin
         r_mem[r_wptr] <= r_mem[r_wptr];
      end
   end

   // FIFO pointers, occupancy, sticky overflow and the registered stop flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= {AW{1'b0}};
         r_rptr  <= {AW{1'b0}};
         r_count <= {CNT_W{1'b0}};
         r_ovf   <= 1'b0;
         r_stop  <= 1'b0;
      end else begin
         if (w_wr) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         r_count <= w_count_nxt;
         r_ovf   <= r_ovf | w_drop;
         // Counts stored and in-flight results, so the credit reserve covers the whole pipeline.
         r_stop  <= (w_occupancy >= STOP_LEVEL);
      end
   end

   // Output drive: the FWFT head is shown only while the FIFO holds data.
   always_comb begin
      dout_valid = (r_count != {CNT_W{1'b0}});
      if (dout_valid) begin
         dout = r_mem[r_rptr];
      end else begin
         dout = {OUT_W{1'b0}};
      end
      count = r_count;
      ovf   = r_ovf;
      stop  = r_stop;
   end

endmodule

// File: tb/tb_fp64_to_fixed_fifo.sv
// -----------------------------------------------------------------------------
// tb_fp64_to_fixed_fifo
//   Scoreboard bench. Stimulus pushes the hand-computed fixed-point value of
//   every operand that should reach the FIFO. A negedge monitor pops the
//   queue and compares it with dout on every dout_valid & dout_ready
//   handshake. Direct checks cover reset, latency, stop, count and ovf.
// -----------------------------------------------------------------------------
module tb_fp64_to_fixed_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        pushin;
   logic [63:0] din;
   logic        stop;
   logic        dout_valid;
   logic        dout_ready;
   logic [31:0] dout;
   logic [4:0]  count;
   logic        ovf;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_q [$];

   logic [63:0] vec_din [8];
   logic [31:0] vec_exp [8];

   always #5 clk = ~clk;

   fp64_to_fixed_fifo dut (
      .clk        (clk),
      .rst        (rst),
      .pushin     (pushin),
      .din        (din),
      .stop       (stop),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout       (dout),
      .count      (count),
      .ovf        (ovf)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic issue(input logic [63:0] d, input logic [31:0] e, input bit expect_out);
      pushin = 1'b1;
      din    = d;
      if (expect_out) exp_q.push_back(e);
      @(posedge clk); #1;
      pushin = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int cyc = 0;
      while ((exp_q.size() != 0 || count != 5'd0) && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      check(name, 64'(exp_q.size()), 64'd0);
   endtask

   // Monitor: every accepted head is compared against the scoreboard.
   always @(negedge clk) begin
      if (!rst && dout_valid && dout_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_output: got %0h, expected nothing (t=%0t)", dout, $time);
         end else begin
            check("dout", 64'(dout), 64'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      vec_din[0] = 64'hC004_0000_0000_0000; vec_exp[0] = 32'hFD80_0000; // -2.5
      vec_din[1] = 64'h3FF0_0000_0000_0001; vec_exp[1] = 32'h0100_0000; // 1.0 + ulp, truncated
      vec_din[2] = 64'h4070_0000_0000_0000; vec_exp[2] = 32'h7FFF_FFFF; // 256 saturates
      vec_din[3] = 64'hC070_0000_0000_0000; vec_exp[3] = 32'h8000_0001; // -256 saturates symmetric
      vec_din[4] = 64'h405F_C000_0000_0000; vec_exp[4] = 32'h7F00_0000; // 127.0
      vec_din[5] = 64'h3E00_0000_0000_0000; vec_exp[5] = 32'h0000_0000; // 2^-31 underflows
      vec_din[6] = 64'h8000_0000_0000_0000; vec_exp[6] = 32'h0000_0000; // -0
      vec_din[7] = 64'h3E70_0000_0000_0000; vec_exp[7] = 32'h0000_0001; // 2^-24, one LSB

      rst = 1'b1; pushin = 1'b0; din = 64'd0; dout_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_count", 64'(count), 64'd0);
      check("rst_dout_valid", 64'(dout_valid), 64'd0);
      check("rst_stop", 64'(stop), 64'd0);
      check("rst_ovf", 64'(ovf), 64'd0);
      check("rst_dout", 64'(dout), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Latency: sampled at E0, written at E2.
      issue(64'h3FF0_0000_0000_0000, 32'h0100_0000, 1'b1);
      check("lat_e0_valid", 64'(dout_valid), 64'd0);
      @(posedge clk); #1;
      check("lat_e1_valid", 64'(dout_valid), 64'd0);
      @(posedge clk); #1;
      check("lat_e2_valid", 64'(dout_valid), 64'd1);
      check("lat_e2_count", 64'(count), 64'd1);
      dout_ready = 1'b1;
      wait_drain("drain_one");

      // Conversion vectors, back to back with the consumer always ready.
      for (int i = 0; i < 8; i++) issue(vec_din[i], vec_exp[i], 1'b1);
      wait_drain("drain_vectors");
      check("ovf_after_vectors", 64'(ovf), 64'd0);

      // Overflow: 17 pushes into a stalled FIFO; the 17th is dropped.
      dout_ready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         issue(64'h3FF0_0000_0000_0000 | (64'(i) << 44),
               32'h0100_0000 + (32'(i) << 16), (i < 16));
         if (i == 2) check("stop_lo_at_2", 64'(stop), 64'd0);
         if (i == 3) check("stop_hi_at_3", 64'(stop), 64'd1);
      end
      @(posedge clk); #1;
      check("full_count", 64'(count), 64'd16);
      check("ovf_before_drop", 64'(ovf), 64'd0);
      @(posedge clk); #1;
      check("drop_count", 64'(count), 64'd16);
      check("drop_ovf", 64'(ovf), 64'd1);
      check("drop_stop", 64'(stop), 64'd1);
      dout_ready = 1'b1;
      repeat (16) @(posedge clk);
      #1;
      check("drain16_count", 64'(count), 64'd0);
      check("drain16_queue", 64'(exp_q.size()), 64'd0);
      check("ovf_sticky", 64'(ovf), 64'd1);

      // Full FIFO with a simultaneous push and pop.
      dout_ready = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      check("ovf_cleared", 64'(ovf), 64'd0);
      for (int i = 0; i < 22; i++) begin
         if (i == 18) dout_ready = 1'b1;
         issue(64'h3FF0_0000_0000_0000 | (64'(i) << 44),
               32'h0100_0000 + (32'(i) << 16), 1'b1);
         if (i >= 17) check("fullpp_count", 64'(count), 64'd16);
         if (i >= 18) check("fullpp_ovf", 64'(ovf), 64'd0);
      end

      // Reset mid-burst discards stored and in-flight data.
      dout_ready = 1'b0;
      pushin = 1'b1;
      din = 64'h3FF0_0000_0000_0000;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      pushin = 1'b0;
      exp_q.delete();
      check("midrst_count", 64'(count), 64'd0);
      check("midrst_dout_valid", 64'(dout_valid), 64'd0);
      check("midrst_stop", 64'(stop), 64'd0);
      check("midrst_ovf", 64'(ovf), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check("midrst_flushed", 64'(count), 64'd0);

      // The block converts normally after the mid-burst reset.
      dout_ready = 1'b1;
      issue(64'h405F_C000_0000_0000, 32'h7F00_0000, 1'b1);
      wait_drain("drain_after_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
